// File: rtl/dr_predictor.sv
// NNZ/column-delta predictor with a 2-bit confidence counter and up to four in-flight predictions.
// A flush trains once, then the remaining squashed predictions drain through RECOVER.
module dr_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        pred_valid,
  output logic [31:0] pred_nnz,
  output logic [15:0] pred_col,
  input  logic        res_valid,
  input  logic        res_flush,
  input  logic [31:0] res_nnz,
  input  logic [15:0] res_col,
  output logic [2:0]  inflight,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StRecover} state_e;

  state_e      state_q, state_d;
  logic [2:0]  inflight_q, inflight_d;
  logic        pred_valid_q, pred_valid_d;
  logic [31:0] pred_nnz_q, pred_nnz_d;
  logic [15:0] pred_col_q, pred_col_d;
  logic [31:0] last_nnz_q, last_nnz_d;
  logic [15:0] last_col_q, last_col_d;
  logic [1:0]  conf_q, conf_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic accept, res_take, train, flush_take;

  assign req_ready = rst && (state_q == StRun) && en && (inflight_q < 3'd4) &&
                     !(res_valid && res_flush);

  always_comb begin
    accept      = req_valid && req_ready;
    // Resolutions with nothing outstanding are stale and ignored entirely.
    res_take    = res_valid && (inflight_q != 3'd0);
    train       = res_take && (state_q == StRun);
    flush_take  = train && res_flush;

    inflight_d  = inflight_q;
    unique case ({accept, res_take})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase

    pred_valid_d = accept;
    pred_nnz_d   = accept ? last_nnz_q : pred_nnz_q;
    pred_col_d   = accept ? last_col_q : pred_col_q;

    conf_d     = conf_q;
    last_nnz_d = last_nnz_q;
    last_col_d = last_col_q;
    if (train) begin
      last_col_d = res_col;
      if (res_nnz == last_nnz_q) begin
        if (conf_q != 2'd3) conf_d = conf_q + 2'd1;
      end else begin
        if (conf_q != 2'd0) conf_d = conf_q - 2'd1;
        else                last_nnz_d = res_nnz;
      end
    end

    flush_cnt_d = flush_cnt_q;
    if (flush_take && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;

    state_d = state_q;
    unique case (state_q)
      StIdle:    if (en) state_d = StRun;
      StRun: begin
        if (flush_take && (inflight_d != 3'd0))    state_d = StRecover;
        else if (!en && (inflight_q == 3'd0))      state_d = StIdle;
      end
      StRecover: if (inflight_d == 3'd0) state_d = StRun;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      inflight_q   <= 3'd0;
      pred_valid_q <= 1'b0;
      pred_nnz_q   <= 32'd0;
      pred_col_q   <= 16'd0;
      last_nnz_q   <= 32'd0;
      last_col_q   <= 16'd0;
      conf_q       <= 2'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      pred_valid_q <= pred_valid_d;
      pred_nnz_q   <= pred_nnz_d;
      pred_col_q   <= pred_col_d;
      last_nnz_q   <= last_nnz_d;
      last_col_q   <= last_col_d;
      conf_q       <= conf_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_nnz   = pred_nnz_q;
  assign pred_col   = pred_col_q;
  assign inflight   = inflight_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_dr_predictor.sv
// Directed, table-driven bench for dr_predictor: each row drives one cycle of inputs and
// checks req_ready before the edge and the registered outputs after it.
module tb_dr_predictor;

  logic        clk = 1'b0;
  logic        rst, en, req_valid, req_ready, pred_valid, res_valid, res_flush;
  logic [31:0] pred_nnz, res_nnz;
  logic [15:0] pred_col, res_col, flush_cnt;
  logic [2:0]  inflight;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst, en, rq, rv, rf;
    logic [31:0] rn;
    logic [15:0] rc;
    logic        rdy, pv;
    logic [31:0] pn;
    logic [15:0] pc;
    logic [2:0]  inf;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];

  dr_predictor dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .pred_valid(pred_valid),
    .pred_nnz  (pred_nnz),
    .pred_col  (pred_col),
    .res_valid (res_valid),
    .res_flush (res_flush),
    .res_nnz   (res_nnz),
    .res_col   (res_col),
    .inflight  (inflight),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, e, q, v, f, input logic [31:0] n, input logic [15:0] c,
                     input logic rdy, pv, input logic [31:0] pn, input logic [15:0] pc,
                     input logic [2:0] inf, input logic [15:0] fc);
    vec_t x;
    x.rst = r; x.en = e; x.rq = q; x.rv = v; x.rf = f; x.rn = n; x.rc = c;
    x.rdy = rdy; x.pv = pv; x.pn = pn; x.pc = pc; x.inf = inf; x.fc = fc;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic r, e, q, v, f, input logic [31:0] n, input logic [15:0] c);
    rst = r; en = e; req_valid = q; res_valid = v; res_flush = f; res_nnz = n; res_col = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    #1;
    //  rst en rq rv rf  rn   rc   | rdy pv pn  pc inf fc
    add(0, 0, 0, 0, 0,   0,   0,     0, 0, 0,  0, 0, 0);  // reset
    add(1, 1, 1, 0, 0,   0,   0,     0, 0, 0,  0, 0, 0);  // IDLE: not ready
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 0,  0, 1, 0);  // first prediction is zero
    add(1, 1, 0, 1, 0,   7,   5,     1, 0, 0,  0, 0, 0);  // conf 0 mismatch: last_nnz=7
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 7,  5, 1, 0);
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 7,  5, 2, 0);
    add(1, 1, 1, 1, 0,   9,   3,     1, 1, 7,  5, 2, 0);  // accept+resolve at 2: pre-update
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  3, 3, 0);
    add(1, 1, 0, 1, 0,   9,   3,     1, 0, 9,  3, 2, 0);  // conf 1
    add(1, 1, 0, 1, 0,   9,   3,     1, 0, 9,  3, 1, 0);  // conf 2
    add(1, 1, 0, 1, 0,   9,   3,     1, 0, 9,  3, 0, 0);  // conf 3
    add(1, 1, 0, 1, 0, 100,  44,     1, 0, 9,  3, 0, 0);  // stale resolve ignored
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  3, 1, 0);
    add(1, 1, 0, 1, 0,   1,   2,     1, 0, 9,  3, 0, 0);  // conf 3->2, nnz kept
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  2, 1, 0);
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  2, 2, 0);
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  2, 3, 0);
    add(1, 1, 1, 1, 1,   9,   8,     0, 0, 9,  2, 2, 1);  // flush at 3 -> RECOVER
    add(1, 1, 1, 1, 1,  50,  50,     0, 0, 9,  2, 1, 1);  // discarded
    add(1, 1, 1, 1, 1,  50,  50,     0, 0, 9,  2, 0, 1);  // discarded, back to RUN
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  8, 1, 1);
    add(1, 0, 1, 1, 0,   9,   8,     0, 0, 9,  8, 0, 1);  // en=0: resolve still completes
    add(1, 0, 0, 0, 0,   0,   0,     0, 0, 9,  8, 0, 1);  // RUN -> IDLE
    add(1, 1, 1, 0, 0,   0,   0,     0, 0, 9,  8, 0, 1);  // IDLE -> RUN
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  8, 1, 1);
    add(1, 1, 1, 1, 1,   4,   1,     0, 0, 9,  8, 0, 2);  // flush at 1 stays RUN
    add(1, 1, 1, 0, 0,   0,   0,     1, 1, 9,  1, 1, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].rq, tbl[i].rv, tbl[i].rf, tbl[i].rn, tbl[i].rc);
      #1;
      chk($sformatf("row%0d req_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].rdy});
      tick();
      chk($sformatf("row%0d pred_valid", i), {31'd0, pred_valid}, {31'd0, tbl[i].pv});
      chk($sformatf("row%0d pred_nnz", i), pred_nnz, tbl[i].pn);
      chk($sformatf("row%0d pred_col", i), {16'd0, pred_col}, {16'd0, tbl[i].pc});
      chk($sformatf("row%0d inflight", i), {29'd0, inflight}, {29'd0, tbl[i].inf});
      chk($sformatf("row%0d flush_cnt", i), {16'd0, flush_cnt}, {16'd0, tbl[i].fc});
    end

    // Five back-to-back requests: only four fit.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
      #1;
      chk($sformatf("burst%0d req_ready", i), {31'd0, req_ready}, {31'd0, (i < 4)});
      tick();
    end
    chk("burst inflight", {29'd0, inflight}, 32'd4);
    chk("burst pred_valid", {31'd0, pred_valid}, 32'd0);

    // Flush at 4 leaves 3 outstanding in RECOVER, then reset mid-recovery.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 16'd3);
    tick();
    chk("rec inflight", {29'd0, inflight}, 32'd3);
    chk("rec flush_cnt", {16'd0, flush_cnt}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    #1;
    chk("rec req_ready", {31'd0, req_ready}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 16'd3);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rst inflight", {29'd0, inflight}, 32'd0);
    chk("rst flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst pred_nnz", pred_nnz, 32'd0);
    chk("rst pred_col", {16'd0, pred_col}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 16'd5);
    tick();
    chk("post-rst inflight", {29'd0, inflight}, 32'd0);
    chk("post-rst flush_cnt", {16'd0, flush_cnt}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
    #1;
    chk("post-rst idle req_ready", {31'd0, req_ready}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
